ddc_cap_ctrl: RTL and testbench

Capture/readout sequencer for the DDC test path. Owns a single-port 512×DATA_W sample RAM and shares its one address/write port between the DDC output stream (write side) and a downstream readout consumer (read side). On `start` it fills the RAM with consecutive DDC samples, then streams the RAM contents out in address order over a valid/ready handshake. It then returns to idle.

---
 rtl/ddc_pkg.sv | 18 +
 rtl/ddc_cap_ctrl_if.sv | 46 ++++
 rtl/ddc_cap_ptr.sv | 41 ++++
 rtl/ddc_cap_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ddc_cap_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddc_pkg.sv
// Shared definitions for the DDC capture/readout sequencer.
//   - cap_state_t : sequencer FSM states
//   - DDC_*       : default address width, capture depth and sample width
package ddc_pkg;

  localparam int unsigned DDC_ADDR_W = 9;
  localparam int unsigned DDC_DEPTH  = 512;
  localparam int unsigned DDC_DATA_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StRdIssue,
    StRdWait,
    StRdHold
  } cap_state_t;

endpackage

// File: rtl/ddc_cap_ctrl_if.sv
// Signal bundle between the capture sequencer and its environment.
//   slave  : sequencer view (ddc_cap_ctrl)
//   master : environment view (DDC source, RAM, readout consumer)
// Groups: capture request/stream (start, din, din_valid), RAM port
// (mem_addr, mem_we, mem_wdata, mem_rdata), readout handshake
// (dout, dout_valid, dout_ready) and status (busy, done, lost).
// Optional macro DDC_CAP_DECIM_EN adds the 4-bit decim input.
interface ddc_cap_ctrl_if #(
  parameter int unsigned ADDR_W = ddc_pkg::DDC_ADDR_W,
  parameter int unsigned DATA_W = ddc_pkg::DDC_DATA_W
);

  logic              start;
  logic [DATA_W-1:0] din;
  logic              din_valid;
`ifdef DDC_CAP_DECIM_EN
  logic [3:0]        decim;
`endif
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              done;
  logic              lost;

  modport slave (
`ifdef DDC_CAP_DECIM_EN
    input  decim,
`endif
    input  start, din, din_valid, mem_rdata, dout_ready,
    output mem_addr, mem_we, mem_wdata, dout, dout_valid, busy, done, lost
  );

  modport master (
`ifdef DDC_CAP_DECIM_EN
    output decim,
`endif
    output start, din, din_valid, mem_rdata, dout_ready,
    input  mem_addr, mem_we, mem_wdata, dout, dout_valid, busy, done, lost
  );

endinterface

// File: rtl/ddc_cap_ptr.sv
// Modulo pointer for the capture RAM.
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : advance by one (wraps from Depth-1 to 0)
//   clr_i    : synchronous clear, wins over en_i
//   cnt_o    : current pointer value
//   tc_o     : pointer is at Depth-1
module ddc_cap_ptr #(
  parameter int unsigned AddrW = 9,
  parameter int unsigned Depth = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [AddrW-1:0] cnt_o,
  output logic             tc_o
);

  logic [AddrW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == AddrW'(Depth - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ddc_cap_ctrl.sv
// Capture/readout sequencer for the DDC test path.
// Fills an external single-port RAM with DEPTH consecutive DDC samples after
// start, then streams them out in address order over dout/dout_valid/
// dout_ready and returns to idle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ddc_cap_ctrl_if.slave (stream in, RAM port, readout, status)
// Optional macro DDC_CAP_DECIM_EN: adds bus.decim; only every (decim+1)-th
// din_valid in capture is written.
module ddc_cap_ctrl
  import ddc_pkg::*;
#(
  parameter int unsigned ADDR_W = DDC_ADDR_W,
  parameter int unsigned DEPTH  = DDC_DEPTH,
  parameter int unsigned DATA_W = DDC_DATA_W
) (
  input logic           clk,
  input logic           rst,
  ddc_cap_ctrl_if.slave bus
);

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              done_q, done_d;
  logic              lost_q, lost_d;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_tc, rd_tc;
  logic              start_ok, keep, wr_fire, rd_accept, rd_phase;

  // A start in the done cycle is dropped: the sequence is still finishing.
  assign start_ok  = (state_q == StIdle) && bus.start && !done_q;
  assign wr_fire   = (state_q == StCapture) && bus.din_valid && keep;
  assign rd_accept = (state_q == StRdHold) && bus.dout_ready;
  assign rd_phase  = (state_q == StRdIssue) || (state_q == StRdWait) ||
                     (state_q == StRdHold);

`ifdef DDC_CAP_DECIM_EN
  logic [3:0] decim_q, decim_d, dec_cnt_q, dec_cnt_d;

  // First din_valid after start is kept, then every (decim+1)-th.
  assign keep = (dec_cnt_q == 4'd0);

  always_comb begin
    decim_d   = decim_q;
    dec_cnt_d = dec_cnt_q;
    if (start_ok) begin
      decim_d   = bus.decim;
      dec_cnt_d = 4'd0;
    end else if ((state_q == StCapture) && bus.din_valid) begin
      dec_cnt_d = (dec_cnt_q == decim_q) ? 4'd0 : dec_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decim_q   <= 4'd0;
      dec_cnt_q <= 4'd0;
    end else begin
      decim_q   <= decim_d;
      dec_cnt_q <= dec_cnt_d;
    end
  end
`else
  assign keep = 1'b1;
`endif

  ddc_cap_ptr #(
    .AddrW (ADDR_W),
    .Depth (DEPTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (wr_fire),
    .clr_i (start_ok),
    .cnt_o (wr_ptr),
    .tc_o  (wr_tc)
  );

  ddc_cap_ptr #(
    .AddrW (ADDR_W),
    .Depth (DEPTH)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (rd_accept),
    .clr_i (start_ok),
    .cnt_o (rd_ptr),
    .tc_o  (rd_tc)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
      lost_q       <= lost_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_ok) state_d = StCapture;
      StCapture: if (wr_fire && wr_tc) state_d = StRdIssue;
      StRdIssue: state_d = StRdWait;
      StRdWait:  state_d = StRdHold;
      StRdHold:  if (rd_accept) state_d = rd_tc ? StIdle : StRdIssue;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic (next values of the registered outputs).
  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    done_d       = 1'b0;
    lost_d       = lost_q;

    case (state_q)
      StCapture: begin
        if (wr_fire) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr;
          mem_wdata_d = bus.din;
        end
      end
      StRdIssue: mem_addr_d = rd_ptr;
      StRdWait: begin
        dout_d       = bus.mem_rdata;
        dout_valid_d = 1'b1;
      end
      StRdHold: begin
        if (rd_accept) begin
          dout_valid_d = 1'b0;
          done_d       = rd_tc;
        end
      end
      default: ;
    endcase

    // Samples arriving during readout are dropped and flagged.
    if (rd_phase && bus.din_valid) begin
      lost_d = 1'b1;
    end
    if (start_ok) begin
      lost_d = 1'b0;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.lost       = lost_q;

endmodule

// File: tb/tb_ddc_cap_ctrl.sv
// Scoreboard bench for ddc_cap_ctrl with a behavioural RAM and reference model.
module tb_ddc_cap_ctrl;
  import ddc_pkg::*;

  localparam int unsigned AW = DDC_ADDR_W;
  localparam int unsigned DW = DDC_DATA_W;
  localparam int unsigned N  = DDC_DEPTH;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddc_cap_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ddc_cap_ctrl #(
    .ADDR_W (AW),
    .DEPTH  (N),
    .DATA_W (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port RAM, read data follows the registered address.
  logic [DW-1:0] ram [N];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  wr_t           exp_wr[$];
  logic [DW-1:0] exp_rd[$];

  // Monitor
  int            cyc = 0;
  int            last_hs = -1;
  bit            rdy_high = 1'b0;
  int            done_cnt = 0;
  logic          hold_p = 1'b0;
  logic [DW-1:0] dout_p;
  logic [AW-1:0] addr_p;
  wr_t           mon_e;
  logic [DW-1:0] mon_d;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_p  = 1'b0;
      last_hs = -1;
    end else begin
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 64'(bus.mem_addr), 64'hFFFF);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", 64'(bus.mem_addr), 64'(mon_e.a));
          chk("wr_data", 64'(bus.mem_wdata), 64'(mon_e.d));
        end
      end
      if (hold_p) begin
        chk("hold_stable", {bus.dout_valid, bus.dout, bus.mem_addr}, {1'b1, dout_p, addr_p});
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_read", 64'(bus.dout), 64'hFFFF_FFFF);
        end else begin
          mon_d = exp_rd.pop_front();
          chk("rd_data", 64'(bus.dout), 64'(mon_d));
        end
        if (rdy_high && last_hs >= 0) chk("rd_throughput", 64'(cyc - last_hs), 64'd3);
        last_hs = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_queues_empty", 64'(exp_rd.size() + exp_wr.size()), 64'd0);
        chk("busy_at_done", 64'(bus.busy), 64'd0);
      end
      hold_p = bus.dout_valid && !bus.dout_ready;
      dout_p = bus.dout;
      addr_p = bus.mem_addr;
    end
  end

  task automatic chk_reset_outs(input string name);
    chk(name, {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.dout, bus.dout_valid,
               bus.busy, bus.done, bus.lost}, 64'd0);
  endtask

  // vmode: 0 continuous din=index, 1 every other cycle, 2 random.
  // rmode: 0 ready tied high, 1 random ready with a 10-cycle stall on sample 5.
  task automatic run_capture(input int vmode, input int rmode, input bit noise,
                             input int abort_at, input int dec);
    int            k = 0;
    int            vcnt = 0;
    int            acc = 0;
    int            guard = 0;
    int            hold5 = 0;
    int            dc0;
    bit            lost_exp = 1'b0;
    logic [DW-1:0] d;

    dc0 = done_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1;
`ifdef DDC_CAP_DECIM_EN
    bus.decim = 4'(dec);
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("lost_cleared_by_start", 64'(bus.lost), 64'd0);
    last_hs  = -1;
    rdy_high = (rmode == 0);

    while (k < N && guard < 8000) begin
      case (vmode)
        0:       bus.din_valid = 1'b1;
        1:       bus.din_valid = (guard % 2 == 0);
        default: bus.din_valid = ($urandom % 3 != 0);
      endcase
      d = (vmode == 0) ? DW'(k) : DW'($urandom);
      bus.din   = d;
      bus.start = noise && ($urandom % 16 == 0);
      if (bus.din_valid) begin
        if (vcnt % (dec + 1) == 0) begin
          exp_wr.push_back('{AW'(k), d});
          exp_rd.push_back(d);
          k++;
        end
        vcnt++;
      end
      @(posedge clk); #1;
      guard++;
      if (abort_at > 0 && k == abort_at) begin
        bus.din_valid = 1'b0;
        bus.start     = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_outs("reset_mid_capture");
        exp_wr.delete();
        exp_rd.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    bus.din_valid = 1'b0;
    bus.start     = 1'b0;
    if (k < N) chk("capture_timeout", 64'(k), 64'(N));

    while (acc < N && guard < 20000) begin
      if (rmode == 0) begin
        bus.dout_ready = 1'b1;
      end else if (acc == 5 && hold5 < 10) begin
        bus.dout_ready = 1'b0;
        if (bus.dout_valid) hold5++;
      end else begin
        bus.dout_ready = ($urandom % 3 != 0);
      end
      bus.din_valid = noise && ($urandom % 8 == 0);
      if (bus.din_valid) lost_exp = 1'b1;
      bus.start = noise && ($urandom % 16 == 0);
      if (bus.dout_valid && bus.dout_ready) acc++;
      @(posedge clk); #1;
      guard++;
    end
    bus.din_valid = 1'b0;
    if (acc < N) chk("readout_timeout", 64'(acc), 64'(N));

    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("busy_low_at_done", 64'(bus.busy), 64'd0);
    bus.start      = 1'b1;
    bus.dout_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_on_done_ignored", 64'(bus.busy), 64'd0);
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("done_count", 64'(done_cnt - dc0), 64'd1);
    chk("lost_flag", 64'(bus.lost), 64'(lost_exp));

    // Samples in idle are neither written nor flagged.
    bus.din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.din_valid = 1'b0;
    chk("idle_din_no_lost_change", 64'(bus.lost), 64'(lost_exp));
    chk("idle_not_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
`ifdef DDC_CAP_DECIM_EN
    bus.decim      = 4'd0;
`endif
    #23;
    chk_reset_outs("reset_values");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("after_reset_idle");

    bus.din_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.din_valid = 1'b0;
    chk("idle_din_no_lost", 64'(bus.lost), 64'd0);

    run_capture(0, 0, 1'b0, 0, 0);
    run_capture(1, 1, 1'b1, 0, 0);
    run_capture(2, 1, 1'b1, 200, 0);
    chk_reset_outs("after_abort");
    run_capture(0, 1, 1'b1, 0, 0);
`ifdef DDC_CAP_DECIM_EN
    run_capture(0, 0, 1'b0, 0, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
